// File: rtl/lock_controller_pkg.sv
// Shared definitions for the keypad lock entry-and-decision stage:
// FSM state encoding, BCD width and the default entry length.
package lock_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_UNLOCK  = 3'd3,
        ST_LOCKOUT = 3'd4
    } lock_state_t;

    localparam int BCD_W          = 4;
    localparam int DEFAULT_DIGITS = 8;

    // Encoder codes above 9 are not decimal digits and are dropped silently.
    function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
        return digit <= BCD_W'(9);
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the unlock and lockout hold periods.
// done is high while the count sits at zero.
module lock_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/lock_controller.sv
// Keypad door lock decision stage: assembles BCD entries from the encoder,
// programs or checks the passcode, counts failures and drives unlock/lockout.
module lock_controller
    import lock_controller_pkg::*;
#(
    parameter int DIGITS         = DEFAULT_DIGITS,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int UNLOCK_CYCLES  = 500,
    parameter int LOCKOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       set_mode,
    input  logic       clear,
    output logic       unlocked,
    output logic       locked_out,
    output logic       code_set,
    output logic       error,
    output logic [3:0] attempt_count,
    output logic [3:0] digit_count
);

    localparam int BUF_W      = BCD_W * DIGITS;
    localparam int MAX_CYCLES = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [TIMER_W-1:0] UNLOCK_LOAD   = TIMER_W'(UNLOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD  = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]         FULL_COUNT    = 4'(DIGITS);
    localparam logic [3:0]         ATTEMPT_LIMIT = 4'(MAX_ATTEMPTS);

    lock_state_t        state, state_next;
    logic               prog, prog_next;
    logic [BUF_W-1:0]   passcode, passcode_next;
    logic [BUF_W-1:0]   entry_buf, entry_buf_next;
    logic [BUF_W-1:0]   shifted_buf;
    logic [3:0]         digit_count_next, attempt_count_next, attempt_inc;
    logic               unlocked_next, locked_out_next, code_set_next, error_next;
    logic               key_valid_q, key_event, digit_ok;
    logic               timer_load, timer_done;
    logic [TIMER_W-1:0] timer_value;

    assign key_event   = key_valid & ~key_valid_q;
    assign digit_ok    = key_event & is_bcd(key_digit);
    assign shifted_buf = {entry_buf[BUF_W-BCD_W-1:0], key_digit};
    assign attempt_inc = attempt_count + 4'd1;

    lock_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (timer_load),
        .value (timer_value),
        .done  (timer_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            prog          <= 1'b0;
            passcode      <= '0;
            entry_buf     <= '0;
            digit_count   <= 4'd0;
            attempt_count <= 4'd0;
            unlocked      <= 1'b0;
            locked_out    <= 1'b0;
            code_set      <= 1'b0;
            error         <= 1'b0;
            key_valid_q   <= 1'b0;
        end else begin
            state         <= state_next;
            prog          <= prog_next;
            passcode      <= passcode_next;
            entry_buf     <= entry_buf_next;
            digit_count   <= digit_count_next;
            attempt_count <= attempt_count_next;
            unlocked      <= unlocked_next;
            locked_out    <= locked_out_next;
            code_set      <= code_set_next;
            error         <= error_next;
            key_valid_q   <= key_valid;
        end
    end

    always_comb begin
        state_next         = state;
        prog_next          = prog;
        passcode_next      = passcode;
        entry_buf_next     = entry_buf;
        digit_count_next   = digit_count;
        attempt_count_next = attempt_count;
        unlocked_next      = unlocked;
        locked_out_next    = locked_out;
        code_set_next      = code_set;
        error_next         = 1'b0;
        timer_load         = 1'b0;
        timer_value        = UNLOCK_LOAD;

        case (state)
            ST_IDLE: begin
                if (digit_ok) begin
                    if (set_mode && code_set) begin
                        error_next = 1'b1;
                    end else begin
                        state_next       = ST_ENTRY;
                        prog_next        = set_mode;
                        entry_buf_next   = shifted_buf;
                        digit_count_next = digit_count + 4'd1;
                    end
                end
            end

            // A full entry is held for one cycle before the decision so that
            // clear can still abandon it and the compare sees a settled buffer.
            ST_ENTRY: begin
                if (clear) begin
                    state_next       = ST_IDLE;
                    entry_buf_next   = '0;
                    digit_count_next = 4'd0;
                end else if (digit_count == FULL_COUNT) begin
                    state_next = ST_CHECK;
                end else if (digit_ok) begin
                    entry_buf_next   = shifted_buf;
                    digit_count_next = digit_count + 4'd1;
                end
            end

            ST_CHECK: begin
                state_next       = ST_IDLE;
                entry_buf_next   = '0;
                digit_count_next = 4'd0;
                if (prog) begin
                    passcode_next      = entry_buf;
                    code_set_next      = 1'b1;
                    attempt_count_next = 4'd0;
                end else if (!code_set) begin
                    error_next = 1'b1;
                end else if (entry_buf == passcode) begin
                    state_next         = ST_UNLOCK;
                    attempt_count_next = 4'd0;
                    unlocked_next      = 1'b1;
                    timer_load         = 1'b1;
                    timer_value        = UNLOCK_LOAD;
                end else if (attempt_inc == ATTEMPT_LIMIT) begin
                    state_next         = ST_LOCKOUT;
                    attempt_count_next = attempt_inc;
                    locked_out_next    = 1'b1;
                    timer_load         = 1'b1;
                    timer_value        = LOCKOUT_LOAD;
                end else begin
                    attempt_count_next = attempt_inc;
                    error_next         = 1'b1;
                end
            end

            ST_UNLOCK: begin
                if (digit_ok && set_mode) begin
                    state_next       = ST_ENTRY;
                    prog_next        = 1'b1;
                    unlocked_next    = 1'b0;
                    entry_buf_next   = shifted_buf;
                    digit_count_next = digit_count + 4'd1;
                end else if (timer_done) begin
                    state_next    = ST_IDLE;
                    unlocked_next = 1'b0;
                end
            end

            ST_LOCKOUT: begin
                if (timer_done) begin
                    state_next         = ST_IDLE;
                    locked_out_next    = 1'b0;
                    attempt_count_next = 4'd0;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
